sad_best_match: RTL and testbench
=================================

// Module: sad_best_match
// PURPOSE
//   Sink end of the SAD pipeline. Consumes the stream of out_sad results from the
//   SAD core, one per candidate block, and selects the best match of a search.
//   A search covers NUM_CAND candidates. The block reports the minimum SAD and the
//   index of the candidate that produced it.
//   The result is handed to the motion-estimation controller with a done/ack handshake.
// PARAMETERS
//   WIDTH     8   pixel width; SAD words are WIDTH+5 bits (32-pixel sum)
//   NUM_CAND  16  candidates per search, >= 2
//   IDX_W     4   candidate index width; 2**IDX_W >= NUM_CAND
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   start      in   1        begin a new search (sampled in IDLE, or in DONE together with ack)
//   sad_valid  in   1        sad_in carries a valid SAD this cycle
//   sad_in     in   WIDTH+5  SAD of current candidate (core out_sad)
//   sad_ready  out  1        block is accepting SADs (high only in COLLECT)
//   cand_idx   out  IDX_W    index of the next candidate expected
//   best_sad   out  WIDTH+5  minimum SAD of current/last search
//   best_idx   out  IDX_W    candidate index of best_sad
//   busy       out  1        high in COLLECT
//   done       out  1        result valid; held until ack
//   ack        in   1        controller has taken the result
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset values: sad_ready=0, busy=0, done=0, cand_idx=0, best_idx=0,
//     best_sad=all ones (2**(WIDTH+5)-1).
//   - rst wins over every other input on the same edge, in any state, including mid-search.
//     After reset the FSM is in IDLE.
//   - FSM states: IDLE, COLLECT, DONE.
//   - IDLE: on start -> COLLECT.
//     At that edge: cand_idx=0, best_sad=all ones, best_idx=0.
//     On the edge that leaves IDLE, sad_ready and busy go 1.
//   - COLLECT: a sample is accepted when sad_valid=1.
//     Gaps in sad_valid are allowed and leave all state unchanged.
//     start is ignored in COLLECT.
//   - On an accepted sample, if sad_in < best_sad (strict, unsigned):
//     best_sad <= sad_in and best_idx <= cand_idx.
//     Ties keep the earlier index. cand_idx <= cand_idx+1.
//   - When the accepted sample has cand_idx == NUM_CAND-1 -> DONE.
//     On that edge: done=1, sad_ready=0, busy=0, cand_idx=0.
//     Latency: done rises 1 cycle after the last accepted sample.
//   - sad_valid outside COLLECT is ignored. No state change, no error.
//   - DONE: done, best_sad and best_idx are held stable until ack=1.
//     ack alone -> IDLE; done=0 on the next edge. best_sad/best_idx keep their values.
//     ack with start in the same cycle -> COLLECT directly (back-to-back search).
//     done=0, and best_sad/best_idx are re-initialised on that edge.
//     start without ack is ignored in DONE.
//   - ack outside DONE is ignored.
//   - A search where every SAD equals all ones reports best_sad=all ones, best_idx=0.
// TESTING
//   1. NUM_CAND=4, start, then SADs 100,50,75,60 on consecutive cycles
//      -> done rises 1 cycle after the 4th; best_sad=50, best_idx=1.
//   2. Ties: SADs 30,30,40,30 -> best_sad=30, best_idx=0.
//   3. All SADs 8191 (WIDTH=8) -> best_sad=8191, best_idx=0, done asserted normally.
//   4. sad_valid every other cycle, start pulsed mid-search, ack delayed 5 cycles
//      -> same result as scenario 1; done and outputs stable for all 5 cycles;
//      done low 1 cycle after ack.
//   5. In DONE, ack=1 and start=1 together, then a new search of 7,3,9,8
//      -> busy=1 next cycle, done=0; second result best_sad=3, best_idx=1.
//   6. rst after 2 accepted samples (80,20) -> next cycle all outputs at reset values.
//      A new search 10,40,5,6 then gives best_sad=5, best_idx=2.

Source files
------------

// File: rtl/sad_best_match.sv
// Best-match selector at the sink of the SAD pipeline: tracks the minimum SAD and its
// candidate index over a search of NUM_CAND candidates, then holds the result until acknowledged.
module sad_best_match #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_CAND = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sad_valid,
  input  logic [WIDTH+4:0]   sad_in,
  output logic               sad_ready,
  output logic [IDX_W-1:0]   cand_idx,
  output logic [WIDTH+4:0]   best_sad,
  output logic [IDX_W-1:0]   best_idx,
  output logic               busy,
  output logic               done,
  input  logic               ack
);

  localparam int unsigned SadW = WIDTH + 5;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CAND - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
  logic [SadW-1:0]  best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cand_idx_q <= '0;
      best_sad_q <= '1;
      best_idx_q <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_idx_q <= cand_idx_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_idx_d = cand_idx_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    done_d     = done_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StCollect;
          cand_idx_d = '0;
          best_sad_d = '1;
          best_idx_d = '0;
          busy_d     = 1'b1;
          ready_d    = 1'b1;
        end
      end

      StCollect: begin
        if (sad_valid) begin
          // Strict compare so ties keep the earlier candidate.
          if (sad_in < best_sad_q) begin
            best_sad_d = sad_in;
            best_idx_d = cand_idx_q;
          end
          if (cand_idx_q == LastIdx) begin
            state_d    = StDone;
            cand_idx_d = '0;
            busy_d     = 1'b0;
            ready_d    = 1'b0;
            done_d     = 1'b1;
          end else begin
            cand_idx_d = cand_idx_q + 1'b1;
          end
        end
      end

      StDone: begin
        if (ack) begin
          done_d = 1'b0;
          if (start) begin
            // Back-to-back search: skip IDLE and re-arm immediately.
            state_d    = StCollect;
            cand_idx_d = '0;
            best_sad_d = '1;
            best_idx_d = '0;
            busy_d     = 1'b1;
            ready_d    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign sad_ready = ready_q;
  assign cand_idx  = cand_idx_q;
  assign best_sad  = best_sad_q;
  assign best_idx  = best_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sad_best_match.sv
// Directed self-checking bench for sad_best_match with a 4-candidate search.
module tb_sad_best_match;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned NUM_CAND = 4;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned AllOnes  = 8191;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             sad_valid = 1'b0;
  logic [WIDTH+4:0] sad_in = '0;
  logic             sad_ready;
  logic [IDX_W-1:0] cand_idx;
  logic [WIDTH+4:0] best_sad;
  logic [IDX_W-1:0] best_idx;
  logic             busy;
  logic             done;
  logic             ack = 1'b0;

  int errors = 0;
  int checks = 0;

  sad_best_match #(
    .WIDTH   (WIDTH),
    .NUM_CAND(NUM_CAND),
    .IDX_W   (IDX_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sad_valid(sad_valid),
    .sad_in   (sad_in),
    .sad_ready(sad_ready),
    .cand_idx (cand_idx),
    .best_sad (best_sad),
    .best_idx (best_idx),
    .busy     (busy),
    .done     (done),
    .ack      (ack)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed4(input int a, input int b, input int c, input int d);
    sad_valid = 1'b1;
    sad_in = (WIDTH+5)'(a); step();
    sad_in = (WIDTH+5)'(b); step();
    sad_in = (WIDTH+5)'(c); step();
    sad_in = (WIDTH+5)'(d); step();
    sad_valid = 1'b0;
    sad_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; ack = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; ack = 1'b0;
    checks++; if (sad_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", sad_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (cand_idx !== 4'd0) begin errors++; $display("FAIL reset_cand_idx: got %0d want 0", cand_idx); end
    checks++; if (best_idx !== 4'd0) begin errors++; $display("FAIL reset_best_idx: got %0d want 0", best_idx); end
    checks++; if (best_sad !== 13'(AllOnes)) begin errors++; $display("FAIL reset_best_sad: got %0d want %0d", best_sad, AllOnes); end
    // ack and sad_valid in IDLE are ignored
    ack = 1'b1; sad_valid = 1'b1; sad_in = 13'd3;
    step();
    ack = 1'b0; sad_valid = 1'b0;
    checks++; if (busy !== 1'b0 || best_sad !== 13'(AllOnes)) begin errors++; $display("FAIL idle_ignore: got busy=%b best_sad=%0d want 0/%0d", busy, best_sad, AllOnes); end
  endtask

  task automatic test_basic();
    start = 1'b1; step(); start = 1'b0;
    checks++; if (busy !== 1'b1 || sad_ready !== 1'b1) begin errors++; $display("FAIL basic_enter: got busy=%b ready=%b want 1/1", busy, sad_ready); end
    checks++; if (cand_idx !== 4'd0) begin errors++; $display("FAIL basic_idx0: got %0d want 0", cand_idx); end
    sad_valid = 1'b1;
    sad_in = 13'd100; step();
    sad_in = 13'd50;  step();
    sad_in = 13'd75;  step();
    checks++; if (cand_idx !== 4'd3 || done !== 1'b0) begin errors++; $display("FAIL basic_mid: got idx=%0d done=%b want 3/0", cand_idx, done); end
    sad_in = 13'd60;  step();
    sad_valid = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done); end
    checks++; if (best_sad !== 13'd50 || best_idx !== 4'd1) begin errors++; $display("FAIL basic_result: got %0d@%0d want 50@1", best_sad, best_idx); end
    checks++; if (busy !== 1'b0 || sad_ready !== 1'b0 || cand_idx !== 4'd0) begin errors++; $display("FAIL basic_exit: got busy=%b ready=%b idx=%0d want 0/0/0", busy, sad_ready, cand_idx); end
    ack = 1'b1; step(); ack = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_ack: got done=%b busy=%b want 0/0", done, busy); end
    checks++; if (best_sad !== 13'd50 || best_idx !== 4'd1) begin errors++; $display("FAIL basic_keep: got %0d@%0d want 50@1", best_sad, best_idx); end
  endtask

  task automatic test_ties();
    start = 1'b1; step(); start = 1'b0;
    feed4(30, 30, 40, 30);
    checks++; if (done !== 1'b1 || best_sad !== 13'd30 || best_idx !== 4'd0) begin errors++; $display("FAIL ties: got done=%b %0d@%0d want 1 30@0", done, best_sad, best_idx); end
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic test_all_ones();
    start = 1'b1; step(); start = 1'b0;
    feed4(8191, 8191, 8191, 8191);
    checks++; if (done !== 1'b1 || best_sad !== 13'(AllOnes) || best_idx !== 4'd0) begin errors++; $display("FAIL all_ones: got done=%b %0d@%0d want 1 8191@0", done, best_sad, best_idx); end
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic test_gaps();
    int vals[4] = '{100, 50, 75, 60};
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sad_valid = 1'b1; sad_in = 13'(vals[i]);
      step();
      if (i == 3) break;
      // Gap cycle: invalid data that would win if wrongly accepted, plus a stray start.
      sad_valid = 1'b0; sad_in = 13'd0; start = (i == 1);
      step();
      start = 1'b0;
      checks++; if (cand_idx !== 4'(i + 1) || done !== 1'b0) begin errors++; $display("FAIL gap_%0d: got idx=%0d done=%b want %0d/0", i, cand_idx, done, i + 1); end
    end
    sad_valid = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gaps_done: got %b want 1", done); end
    // Hold DONE for 5 cycles while start and sad_valid are driven without ack.
    start = 1'b1; sad_valid = 1'b1; sad_in = 13'd1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (done !== 1'b1 || best_sad !== 13'd50 || best_idx !== 4'd1 || busy !== 1'b0) begin errors++; $display("FAIL hold_%0d: got done=%b %0d@%0d busy=%b want 1 50@1 0", k, done, best_sad, best_idx, busy); end
    end
    start = 1'b0; sad_valid = 1'b0; ack = 1'b1;
    step(); ack = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || best_sad !== 13'd50) begin errors++; $display("FAIL gaps_ack: got done=%b busy=%b sad=%0d want 0/0/50", done, busy, best_sad); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; step(); start = 1'b0;
    feed4(100, 50, 75, 60);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done); end
    ack = 1'b1; start = 1'b1; step(); ack = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || sad_ready !== 1'b1) begin errors++; $display("FAIL b2b_rearm: got busy=%b done=%b ready=%b want 1/0/1", busy, done, sad_ready); end
    checks++; if (best_sad !== 13'(AllOnes) || best_idx !== 4'd0) begin errors++; $display("FAIL b2b_reinit: got %0d@%0d want 8191@0", best_sad, best_idx); end
    feed4(7, 3, 9, 8);
    checks++; if (done !== 1'b1 || best_sad !== 13'd3 || best_idx !== 4'd1) begin errors++; $display("FAIL b2b_second: got done=%b %0d@%0d want 1 3@1", done, best_sad, best_idx); end
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic test_mid_reset();
    start = 1'b1; step(); start = 1'b0;
    sad_valid = 1'b1;
    sad_in = 13'd80; step();
    sad_in = 13'd20; step();
    checks++; if (cand_idx !== 4'd2 || best_sad !== 13'd20) begin errors++; $display("FAIL mid_progress: got idx=%0d sad=%0d want 2/20", cand_idx, best_sad); end
    // Reset wins over a valid sample and start on the same edge.
    rst = 1'b1; start = 1'b1; sad_in = 13'd5; step();
    rst = 1'b0; start = 1'b0; sad_valid = 1'b0;
    checks++; if (busy !== 1'b0 || sad_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: got busy=%b ready=%b done=%b want 0/0/0", busy, sad_ready, done); end
    checks++; if (cand_idx !== 4'd0 || best_idx !== 4'd0 || best_sad !== 13'(AllOnes)) begin errors++; $display("FAIL mid_rst_data: got idx=%0d %0d@%0d want 0 8191@0", cand_idx, best_sad, best_idx); end
    start = 1'b1; step(); start = 1'b0;
    feed4(10, 40, 5, 6);
    checks++; if (done !== 1'b1 || best_sad !== 13'd5 || best_idx !== 4'd2) begin errors++; $display("FAIL mid_new_search: got done=%b %0d@%0d want 1 5@2", done, best_sad, best_idx); end
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  initial begin
    step();
    test_reset();
    test_basic();
    test_ties();
    test_all_ones();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
